rael_seq_ctrl: RTL and testbench
================================

Name: rael_seq_ctrl

Overview:
- Synthesizable sequencer that drives the combinational `rael` datapath (`ontiveros` 8 bit, `rami` 2 bit, `Y` 32 bit) in a fixed two-phase sweep.
- Phase 1: `rami`=P1_SEL, `ontiveros` steps P1_FIRST..P1_LAST, each value held P1_HOLD cycles.
- Gap: GAP cycles with outputs frozen.
- Phase 2: `rami`=P2_SEL, `ontiveros` steps P2_FIRST..P2_LAST, each value held P2_HOLD cycles.
- Captures `Y` once per step and streams the samples out. Sits beside `rael` as its on-chip stimulus/scheduler.

Parameters:
- DATA_W, 8, width of ontiveros_o
- SEL_W, 2, width of rami_o
- Y_W, 32, width of y_i / sample_y
- P1_SEL, 2'b00, rami value in phase 1
- P1_FIRST, 0, first ontiveros value in phase 1
- P1_LAST, 10, last ontiveros value in phase 1
- P1_HOLD, 10, cycles per step in phase 1 (>=1)
- GAP, 5, idle cycles between phases (0 = no gap)
- P2_SEL, 2'b10, rami value in phase 2
- P2_FIRST, 11, first ontiveros value in phase 2
- P2_LAST, 20, last ontiveros value in phase 2
- P2_HOLD, 5, cycles per step in phase 2 (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- abort  in  1  synchronous cancel; highest priority after reset
- y_i  in  Y_W  rael.Y
- ontiveros_o  out  DATA_W  to rael.ontiveros (registered)
- rami_o  out  SEL_W  to rael.rami (registered)
- sample_valid  out  1  one-cycle strobe, sample_y/sample_idx valid
- sample_y  out  Y_W  captured Y
- sample_idx  out  5  step index, 0..20 with defaults
- busy  out  1  high in PH1/GAP/PH2
- done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset (async, rst_n=0): all outputs 0; state IDLE; hold counter and index cleared.
- States: IDLE, PH1, GAP, PH2, DONE. Encoding comes from the package.
- IDLE:
  - Outputs ontiveros_o=0, rami_o=0.
  - start=1 at edge k enters PH1 at k+1, with ontiveros_o=P1_FIRST, rami_o=P1_SEL and busy=1 from k+1.
- PH1/PH2 step timing:
  - Hold counter runs 0..HOLD-1.
  - On the last hold cycle, y_i is captured.
  - Next cycle: sample_valid=1, sample_y=captured value, sample_idx=step number; ontiveros_o advances by 1, or the state changes.
- PH1 after P1_LAST: go to GAP if GAP>0, else straight to PH2.
- GAP: ontiveros_o=P1_LAST and rami_o=P1_SEL held for GAP cycles; no samples.
- PH2 entry: ontiveros_o=P2_FIRST, rami_o=P2_SEL.
- PH2 after P2_LAST: enter DONE. DONE lasts one cycle: done=1, busy=0, final sample_valid=1. Then IDLE.
- Default timeline (start at cycle 0):
  - PH1: cycles 1..110
  - GAP: cycles 111..115
  - PH2: cycles 116..165
  - DONE: cycle 166
  - Total 21 samples.
- Arithmetic: ontiveros increments in DATA_W bits. FIRST<=LAST is required (elaboration check), so the counter never wraps. sample_idx wraps never (max 20 with defaults).
- start while busy: ignored, no queuing.
- start and abort in the same IDLE cycle: abort wins, remain IDLE.
- abort in any state: IDLE next cycle, outputs to IDLE values. No done, no further sample_valid; a sample already registered for that edge is suppressed.
- rst_n asserted mid-sweep: immediate return to reset values; the sweep is not resumed.

Optional Feature:
- Macro: RAEL_SEQ_CHECKSUM_EN.
- Defined:
  - Extra output `checksum` (Y_W) holds the running XOR of every sample_y in the current sweep.
  - Cleared on start acceptance, abort and reset.
  - Final value is valid in the DONE cycle and held until the next start.
- Undefined: port and logic absent; otherwise identical behaviour.

Decomposition:
- Package `rael_pkg`:
  - state enum `rael_state_t` {IDLE, PH1, GAP, PH2, DONE}
  - localparams DATA_W=8, SEL_W=2, Y_W=32, IDX_W=5
- Sub-module `rael_step_timer`:
  - Hold counter with `load`, `hold_len` and `expire` output.
  - One instance; reused for both step hold and GAP count.

Test Plan:
- Reset then start at cycle 0:
  - ontiveros_o=0, rami_o=00 at cycle 1; ontiveros_o=1 at cycle 11; ontiveros_o=10 through cycle 115.
  - rami_o=10 and ontiveros_o=11 at cycle 116; ontiveros_o=20 at cycles 161..165; done=1 at cycle 166.
- Bind the real `rael` (or a model with Y={24'h0, ontiveros^{6'h0,rami}}):
  - 21 sample_valid pulses, sample_idx 0..20.
  - sample_y equals the model output for each (ontiveros, rami) pair.
- start pulsed again at cycle 50: no effect, timeline unchanged.
- abort at cycle 120 (in PH2): IDLE at 121, outputs 0, busy=0, no done, no sample after cycle 121.
- rst_n low at cycle 60 for 3 cycles: outputs 0 asynchronously; a new start sweeps cleanly from ontiveros=0.
- With RAEL_SEQ_CHECKSUM_EN defined: checksum in the DONE cycle equals the XOR of all 21 sample_y values; GAP=0 build goes PH1 to PH2 with no frozen cycles (PH2 begins at cycle 111).

Source files
------------

// File: rtl/rael_pkg.sv
// Shared types and widths for the rael sweep sequencer.
// Build option: RAEL_SEQ_CHECKSUM_EN adds a running XOR of samples.
package rael_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 2;
    localparam int Y_W    = 32;
    localparam int IDX_W  = 5;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PH1,
        S_GAP,
        S_PH2,
        S_DONE
    } rael_state_t;

endpackage

// File: rtl/rael_step_timer.sv
// Reloadable hold counter shared by step holds and the inter-phase gap.
// expire is high on the last cycle of the loaded length.
module rael_step_timer
    import rael_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] hold_len,
    output logic         expire
);

    logic [W-1:0] cnt;
    logic [W-1:0] len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            len_q <= '0;
        end else if (load) begin
            cnt   <= '0;
            len_q <= hold_len;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == len_q - 1'b1);

endmodule

// File: rtl/rael_seq_ctrl.sv
// Two-phase stimulus sweep for the rael datapath with per-step capture.
// Build option: RAEL_SEQ_CHECKSUM_EN adds the checksum output.
module rael_seq_ctrl
    import rael_pkg::*;
#(
    parameter int               DATA_W   = rael_pkg::DATA_W,
    parameter int               SEL_W    = rael_pkg::SEL_W,
    parameter int               Y_W      = rael_pkg::Y_W,
    parameter logic [SEL_W-1:0] P1_SEL   = 2'b00,
    parameter int               P1_FIRST = 0,
    parameter int               P1_LAST  = 10,
    parameter int               P1_HOLD  = 10,
    parameter int               GAP      = 5,
    parameter logic [SEL_W-1:0] P2_SEL   = 2'b10,
    parameter int               P2_FIRST = 11,
    parameter int               P2_LAST  = 20,
    parameter int               P2_HOLD  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [Y_W-1:0]    y_i,
    output logic [DATA_W-1:0] ontiveros_o,
    output logic [SEL_W-1:0]  rami_o,
    output logic              sample_valid,
    output logic [Y_W-1:0]    sample_y,
    output logic [IDX_W-1:0]  sample_idx,
    output logic              busy,
    output logic              done
`ifdef RAEL_SEQ_CHECKSUM_EN
    ,
    output logic [Y_W-1:0]    checksum
`endif
);

    if (P1_FIRST > P1_LAST) begin : g_bad_p1
        $error("P1_FIRST must not exceed P1_LAST");
    end
    if (P2_FIRST > P2_LAST) begin : g_bad_p2
        $error("P2_FIRST must not exceed P2_LAST");
    end
    if (P1_HOLD < 1 || P2_HOLD < 1) begin : g_bad_hold
        $error("hold lengths must be at least 1");
    end

    localparam logic [DATA_W-1:0] P1_F = DATA_W'(P1_FIRST);
    localparam logic [DATA_W-1:0] P1_L = DATA_W'(P1_LAST);
    localparam logic [DATA_W-1:0] P2_F = DATA_W'(P2_FIRST);
    localparam logic [DATA_W-1:0] P2_L = DATA_W'(P2_LAST);
    localparam logic [CNT_W-1:0]  H1   = CNT_W'(P1_HOLD);
    localparam logic [CNT_W-1:0]  H2   = CNT_W'(P2_HOLD);
    localparam logic [CNT_W-1:0]  HG   = CNT_W'(GAP);

    rael_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic              t_load;
    logic [CNT_W-1:0]  t_len;
    logic              expire;
    logic              at_l1;
    logic              at_l2;

    assign at_l1 = (ontiveros_o == P1_L);
    assign at_l2 = (ontiveros_o == P2_L);

    // Timer reload length is chosen for the interval that starts next.
    always_comb begin
        t_load = 1'b0;
        t_len  = H1;
        unique case (state)
            S_IDLE: begin
                t_load = start & ~abort;
            end
            S_PH1: begin
                t_load = expire;
                if (at_l1)
                    t_len = (GAP > 0) ? HG : H2;
            end
            S_GAP: begin
                t_load = expire;
                t_len  = H2;
            end
            S_PH2: begin
                t_load = expire;
                t_len  = H2;
            end
            default: ;
        endcase
    end

    rael_step_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .hold_len (t_len),
        .expire   (expire)
    );

`ifdef RAEL_SEQ_CHECKSUM_EN
    logic [Y_W-1:0] csum_q;
    assign checksum = csum_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            ontiveros_o  <= '0;
            rami_o       <= '0;
            sample_valid <= 1'b0;
            sample_y     <= '0;
            sample_idx   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef RAEL_SEQ_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            if (abort) begin
                state       <= S_IDLE;
                idx         <= '0;
                ontiveros_o <= '0;
                rami_o      <= '0;
                sample_y    <= '0;
                sample_idx  <= '0;
                busy        <= 1'b0;
`ifdef RAEL_SEQ_CHECKSUM_EN
                csum_q      <= '0;
`endif
            end else begin
                // A step's sample is taken on its final hold cycle.
                if ((state == S_PH1 || state == S_PH2) && expire) begin
                    sample_valid <= 1'b1;
                    sample_y     <= y_i;
                    sample_idx   <= idx;
                    idx          <= idx + 1'b1;
`ifdef RAEL_SEQ_CHECKSUM_EN
                    csum_q       <= csum_q ^ y_i;
`endif
                end
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            state       <= S_PH1;
                            idx         <= '0;
                            ontiveros_o <= P1_F;
                            rami_o      <= P1_SEL;
                            busy        <= 1'b1;
`ifdef RAEL_SEQ_CHECKSUM_EN
                            csum_q      <= '0;
`endif
                        end
                    end
                    S_PH1: begin
                        if (expire) begin
                            if (!at_l1) begin
                                ontiveros_o <= ontiveros_o + 1'b1;
                            end else if (GAP > 0) begin
                                state <= S_GAP;
                            end else begin
                                state       <= S_PH2;
                                ontiveros_o <= P2_F;
                                rami_o      <= P2_SEL;
                            end
                        end
                    end
                    S_GAP: begin
                        if (expire) begin
                            state       <= S_PH2;
                            ontiveros_o <= P2_F;
                            rami_o      <= P2_SEL;
                        end
                    end
                    S_PH2: begin
                        if (expire) begin
                            if (at_l2) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                ontiveros_o <= ontiveros_o + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state       <= S_IDLE;
                        ontiveros_o <= '0;
                        rami_o      <= '0;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rael_seq_ctrl.sv
// Bench for rael_seq_ctrl: timeline table, sample scoreboard, abort/reset.
// Build option: RAEL_SEQ_CHECKSUM_EN also checks the checksum output.
module tb_rael_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] y_i;
    logic [7:0]  ont;
    logic [1:0]  rami;
    logic        sv;
    logic [31:0] sy;
    logic [4:0]  sidx;
    logic        busy;
    logic        done;
    logic [31:0] y0;
    logic [7:0]  ont0;
    logic [1:0]  rami0;
    logic        sv0;
    logic [31:0] sy0;
    logic [4:0]  sidx0;
    logic        busy0;
    logic        done0;
`ifdef RAEL_SEQ_CHECKSUM_EN
    logic [31:0] csum;
    logic [31:0] csum0;
`endif

    always #5 clk = ~clk;

    // Stand-in for the rael datapath.
    assign y_i = {24'h0, ont ^ {6'h0, rami}};
    assign y0  = {24'h0, ont0 ^ {6'h0, rami0}};

    rael_seq_ctrl u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .y_i          (y_i),
        .ontiveros_o  (ont),
        .rami_o       (rami),
        .sample_valid (sv),
        .sample_y     (sy),
        .sample_idx   (sidx),
        .busy         (busy),
        .done         (done)
`ifdef RAEL_SEQ_CHECKSUM_EN
        ,
        .checksum     (csum)
`endif
    );

    rael_seq_ctrl #(
        .GAP (0)
    ) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .y_i          (y0),
        .ontiveros_o  (ont0),
        .rami_o       (rami0),
        .sample_valid (sv0),
        .sample_y     (sy0),
        .sample_idx   (sidx0),
        .busy         (busy0),
        .done         (done0)
`ifdef RAEL_SEQ_CHECKSUM_EN
        ,
        .checksum     (csum0)
`endif
    );

    typedef struct {
        int         cyc;
        logic [7:0] ont;
        logic [1:0] rami;
        logic       busy;
        logic       done;
        bit         chk_out;
    } vec_t;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] y;
        int          cyc;
    } smp_t;

    vec_t        vec[15];
    smp_t        sbq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          smp_cnt = 0;
    int          done_cnt = 0;
    int          cnt0 = 0;
    logic [31:0] exp_xor;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    // Expected sample i: ontiveros=i, rami 0 in phase 1 (i<=10), 2 after.
    task automatic push_sweep(input int n);
        logic [7:0] o;
        logic [1:0] r;
        smp_t       s;
        exp_xor = '0;
        for (int i = 0; i < n; i++) begin
            o     = 8'(i);
            r     = (i <= 10) ? 2'd0 : 2'd2;
            s.idx = 5'(i);
            s.y   = {24'h0, o ^ {6'h0, r}};
            s.cyc = (i <= 10) ? 10 * i + 11 : 5 * i + 66;
            exp_xor ^= s.y;
            sbq.push_back(s);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (sv0) cnt0++;
            if (sv) begin
                smp_cnt++;
                if (sbq.size() == 0) begin
                    check("unexpected_sample", 32'(sidx), 32'hffff_ffff);
                end else begin
                    check("sample_idx", 32'(sidx), 32'(sbq[0].idx));
                    check("sample_y", sy, sbq[0].y);
                    check("sample_cyc", 32'(cyc), 32'(sbq[0].cyc));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic run(input int abort_at, input int rst_at,
                       input int n_exp, input int exp_done);
        push_sweep(n_exp);
        smp_cnt  = 0;
        done_cnt = 0;
        cnt0     = 0;
        @(negedge clk);
        cyc   = 0;
        start = 1'b1;
        while (cyc < 175) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start = (cyc == 50);
            abort = (cyc == abort_at);
            foreach (vec[i]) begin
                if (vec[i].cyc == cyc && cyc <= abort_at && cyc <= rst_at) begin
                    if (vec[i].chk_out) begin
                        check("ontiveros", 32'(ont), 32'(vec[i].ont));
                        check("rami", 32'(rami), 32'(vec[i].rami));
                    end
                    check("busy", 32'(busy), 32'(vec[i].busy));
                    check("done", 32'(done), 32'(vec[i].done));
                end
            end
            if (cyc == abort_at + 1) begin
                check("abort_ont", 32'(ont), 32'd0);
                check("abort_rami", 32'(rami), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_sv", 32'(sv), 32'd0);
            end
            if (exp_done != 0) begin
                if (cyc == 110) check("gap0_ont110", 32'(ont0), 32'd10);
                if (cyc == 111) begin
                    check("gap0_ont111", 32'(ont0), 32'd11);
                    check("gap0_rami111", 32'(rami0), 32'd2);
                end
                if (cyc == 160) check("gap0_busy160", 32'(busy0), 32'd1);
                if (cyc == 161) check("gap0_done161", 32'(done0), 32'd1);
`ifdef RAEL_SEQ_CHECKSUM_EN
                if (cyc == 166) check("checksum", csum, exp_xor);
`endif
            end
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_ont", 32'(ont), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_sy", sy, 32'd0);
            end
            if (cyc == rst_at + 3) rst_n = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
        check("sample_count", 32'(smp_cnt), 32'(n_exp));
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("queue_left", 32'(sbq.size()), 32'd0);
        if (exp_done != 0) check("gap0_samples", 32'(cnt0), 32'd21);
    endtask

    initial begin
        vec[0]  = '{1,   8'd0,  2'd0, 1'b1, 1'b0, 1'b1};
        vec[1]  = '{10,  8'd0,  2'd0, 1'b1, 1'b0, 1'b1};
        vec[2]  = '{11,  8'd1,  2'd0, 1'b1, 1'b0, 1'b1};
        vec[3]  = '{60,  8'd5,  2'd0, 1'b1, 1'b0, 1'b1};
        vec[4]  = '{101, 8'd10, 2'd0, 1'b1, 1'b0, 1'b1};
        vec[5]  = '{111, 8'd10, 2'd0, 1'b1, 1'b0, 1'b1};
        vec[6]  = '{115, 8'd10, 2'd0, 1'b1, 1'b0, 1'b1};
        vec[7]  = '{116, 8'd11, 2'd2, 1'b1, 1'b0, 1'b1};
        vec[8]  = '{120, 8'd11, 2'd2, 1'b1, 1'b0, 1'b1};
        vec[9]  = '{121, 8'd12, 2'd2, 1'b1, 1'b0, 1'b1};
        vec[10] = '{161, 8'd20, 2'd2, 1'b1, 1'b0, 1'b1};
        vec[11] = '{165, 8'd20, 2'd2, 1'b1, 1'b0, 1'b1};
        vec[12] = '{166, 8'd0,  2'd0, 1'b0, 1'b1, 1'b0};
        vec[13] = '{167, 8'd0,  2'd0, 1'b0, 1'b0, 1'b1};
        vec[14] = '{170, 8'd0,  2'd0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ont", 32'(ont), 32'd0);
        check("reset_rami", 32'(rami), 32'd0);
        check("reset_sv", 32'(sv), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sidx", 32'(sidx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(999, 999, 21, 1);
        run(120, 999, 11, 0);
        run(999, 60, 5, 0);
        run(999, 999, 21, 1);

        // start and abort together in IDLE: abort wins.
        smp_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", 32'(busy), 32'd0);
        check("sa_ont", 32'(ont), 32'd0);
        repeat (15) @(negedge clk);
        check("sa_ont_late", 32'(ont), 32'd0);
        check("sa_samples", 32'(smp_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
